// File: rtl/ibuff_instr_reader.sv
// Read side of the front-end instruction buffer: a DEPTH-entry FIFO of fetched cache lines
// that hands one 32-bit instruction per cycle to decode, tracking the word offset in the head line.
module ibuff_instr_reader #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CL_SIZE = 128,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     line_valid_in,
    input  logic [CL_SIZE-1:0]       line_in,
    input  logic [XLEN-1:0]          line_pc_in,
    input  logic                     line_exc_in,
    output logic                     line_ready_out,
    output logic                     instr_valid_out,
    input  logic                     instr_ready_in,
    output logic [31:0]              instr_out,
    output logic [XLEN-1:0]          instr_pc_out,
    output logic                     instr_exc_out,
    output logic [$clog2(DEPTH):0]   occupancy_out
);

    localparam int unsigned WORDS = CL_SIZE / 32;
    localparam int unsigned OFFW  = $clog2(WORDS);
    localparam int unsigned PW    = $clog2(DEPTH);

    localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [OFFW-1:0] LAST_OFF = OFFW'(WORDS - 1);

    logic [WORDS-1:0][31:0] line_mem [DEPTH];
    logic [XLEN-1:2]        pc_mem   [DEPTH];
    logic [DEPTH-1:0]       exc_mem;

    logic [PW-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [PW:0]     count;
    logic [OFFW-1:0] rd_off, in_off, nxt_off;
    logic            wr_en, xfer, retire, head_exc;
    logic [XLEN-1:2] head_pc;

    // Byte-offset bits of the fetch PC carry no information for word-granular fetch
    logic unused_pc_bits;
    assign unused_pc_bits = ^line_pc_in[1:0];

    assign line_ready_out  = (count < CNT_FULL);
    assign instr_valid_out = (count != '0);
    assign occupancy_out   = count;

    assign wr_en      = line_valid_in && line_ready_out;
    assign rd_ptr_nxt = rd_ptr + PW'(1);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_exc   = exc_mem[rd_ptr];
    assign in_off     = line_pc_in[OFFW+1:2];
    assign xfer       = instr_valid_out && instr_ready_in;
    // An exception line carries a single instruction, so it always retires on its transfer
    assign retire     = xfer && (head_exc || (rd_off == LAST_OFF));

    // Start offset of the line that becomes head after a retire; the successor may be
    // arriving in this very cycle when the retiring line is the only one stored.
    always_comb begin
        nxt_off = '0;
        if (count == (PW+1)'(1)) begin
            if (wr_en) nxt_off = in_off;
        end else begin
            nxt_off = pc_mem[rd_ptr_nxt][OFFW+1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[wr_ptr] <= line_in;
            pc_mem[wr_ptr]   <= line_pc_in[XLEN-1:2];
            exc_mem[wr_ptr]  <= line_exc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_off <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (retire) rd_ptr <= rd_ptr_nxt;
            unique case ({wr_en, retire})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (count == '0) begin
                if (wr_en) rd_off <= in_off;
            end else if (retire) begin
                rd_off <= nxt_off;
            end else if (xfer) begin
                rd_off <= rd_off + OFFW'(1);
            end
        end
    end

    always_comb begin
        instr_out     = '0;
        instr_pc_out  = '0;
        instr_exc_out = 1'b0;
        if (instr_valid_out) begin
            instr_exc_out = head_exc;
            instr_out     = head_exc ? 32'h0 : line_mem[rd_ptr][rd_off];
            instr_pc_out  = {head_pc[XLEN-1:OFFW+2], rd_off, 2'b00};
        end
    end

endmodule
